// File: rtl/mb_rtu_pkg.sv
// Shared Modbus RTU transmit definitions: function/exception codes, CRC
// constants, read-size limit, FSM state encoding and frame classification.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package mb_rtu_pkg;

  localparam logic [7:0] FUN_RD_HOLDING  = 8'h03;
  localparam logic [7:0] FUN_RD_INPUT    = 8'h04;
  localparam logic [7:0] FUN_WR_SINGLE   = 8'h06;
  localparam logic [7:0] FUN_WR_MULTIPLE = 8'h10;

  localparam logic [7:0] EXC_FLAG        = 8'h80;
  localparam logic [7:0] EXC_ILLEGAL_FUN = 8'h01;
  localparam logic [7:0] EXC_ILLEGAL_VAL = 8'h03;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  localparam logic [15:0] MAX_READ_REGS = 16'd125;

  // Each state names the kind of byte currently on mb_txd.
  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CRC_LO,
    CRC_HI,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    FRM_READ,
    FRM_WRITE,
    FRM_EXC
  } frame_kind_e;

  // Latched transmit request.
  typedef struct packed {
    logic [7:0]  fun;
    logic [15:0] addr;
    logic [15:0] num;
  } req_t;

  function automatic logic is_read_fun(input logic [7:0] fun);
    return (fun == FUN_RD_HOLDING) || (fun == FUN_RD_INPUT);
  endfunction

  function automatic frame_kind_e frame_kind(input req_t r);
    frame_kind_e k;
    k = FRM_EXC;
    if (is_read_fun(r.fun) && (r.num != 16'd0) && (r.num <= MAX_READ_REGS))
      k = FRM_READ;
    else if ((r.fun == FUN_WR_SINGLE) || (r.fun == FUN_WR_MULTIPLE))
      k = FRM_WRITE;
    return k;
  endfunction

  // A read code only lands in the exception path when the count is bad.
  function automatic logic [7:0] exc_code(input logic [7:0] fun);
    return is_read_fun(fun) ? EXC_ILLEGAL_VAL : EXC_ILLEGAL_FUN;
  endfunction

endpackage

// File: rtl/mb_crc16.sv
// One-byte CRC-16/Modbus update (reflected, LSB first), purely combinational.
// Latency: 0 cycles. Backpressure: none.
// Ports: crc_in (running CRC), data (next byte), crc_out (CRC after data).
module mb_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  import mb_rtu_pkg::*;

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/mb_rtu_tx.sv
// Modbus RTU response framer: builds header, streams payload, appends CRC.
// Latency: first byte the cycle after tx_en_pulse; one byte per cycle after.
// Backpressure: none; reg_data must be valid whenever payload_req_o is high,
//   and tx_en_pulse is ignored while a frame is in flight.
// Ports: clk, rst_n (async, active HIGH), tx_en_pulse/mb_addr/mb_num/mb_fun
//   (request, latched at start), reg_data/payload_req_o (payload fetch),
//   mb_tx_en/mb_txd (byte stream), tx_done (end-of-frame pulse).
module mb_rtu_tx #(
  parameter logic [7:0] DEV_ADDR = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en_pulse,
  input  logic [15:0] mb_addr,
  input  logic [15:0] mb_num,
  input  logic [7:0]  mb_fun,
  input  logic [7:0]  reg_data,
  output logic        payload_req_o,
  output logic        tx_done,
  output logic        mb_tx_en,
  output logic [7:0]  mb_txd
);
  import mb_rtu_pkg::*;

  state_e      state;
  req_t        req;
  req_t        req_in;
  logic [2:0]  hdr_idx;    // index of the header byte currently on mb_txd
  logic [7:0]  pay_left;   // payload bytes still to be sampled
  logic [15:0] crc;        // CRC over every byte sent so far

  frame_kind_e kind;
  logic [7:0]  hdr [0:7];
  logic [2:0]  hdr_last;
  logic        hdr_more;
  logic [7:0]  crc_dat;
  logic [15:0] crc_nxt;

  assign req_in = '{fun: mb_fun, addr: mb_addr, num: mb_num};

  // Header bytes derived from the latched request.
  always_comb begin
    kind     = frame_kind(req);
    hdr[0]   = DEV_ADDR;
    hdr[1]   = req.fun;
    hdr[2]   = 8'h00;
    hdr[3]   = 8'h00;
    hdr[4]   = 8'h00;
    hdr[5]   = 8'h00;
    hdr[6]   = 8'h00;
    hdr[7]   = 8'h00;
    hdr_last = 3'd2;
    case (kind)
      FRM_READ: begin
        hdr[2] = {req.num[6:0], 1'b0};   // byte count = 2 * registers
      end
      FRM_WRITE: begin
        hdr[2]   = req.addr[15:8];
        hdr[3]   = req.addr[7:0];
        hdr[4]   = req.num[15:8];
        hdr[5]   = req.num[7:0];
        hdr_last = 3'd5;
      end
      default: begin
        hdr[1] = req.fun | EXC_FLAG;
        hdr[2] = exc_code(req.fun);
      end
    endcase
  end

  assign hdr_more = (hdr_idx != hdr_last);

  // The byte about to be loaded into mb_txd, when it is a CRC-covered byte.
  always_comb begin
    crc_dat = reg_data;
    case (state)
      IDLE, DONE: crc_dat = DEV_ADDR;
      HEADER:     crc_dat = hdr_more ? hdr[hdr_idx + 3'd1] : reg_data;
      default:    crc_dat = reg_data;
    endcase
  end

  mb_crc16 u_crc (
    .crc_in  (crc),
    .data    (crc_dat),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      req           <= '0;
      hdr_idx       <= 3'd0;
      pay_left      <= 8'd0;
      crc           <= CRC_INIT;
      payload_req_o <= 1'b0;
      tx_done       <= 1'b0;
      mb_tx_en      <= 1'b0;
      mb_txd        <= 8'h00;
    end else begin
      tx_done <= 1'b0;
      case (state)
        // DONE accepts a start exactly like IDLE, giving back-to-back frames.
        IDLE, DONE: begin
          if (tx_en_pulse) begin
            req      <= req_in;
            hdr_idx  <= 3'd0;
            mb_tx_en <= 1'b1;
            mb_txd   <= crc_dat;
            crc      <= crc_nxt;
            state    <= HEADER;
          end else begin
            state <= IDLE;
          end
        end

        HEADER, PAYLOAD: begin
          if (state == HEADER && hdr_more) begin
            hdr_idx <= hdr_idx + 3'd1;
            mb_txd  <= crc_dat;
            crc     <= crc_nxt;
            // Loading the byte count: the payload request window opens with it.
            if (kind == FRM_READ && hdr_idx == 3'd1) begin
              payload_req_o <= 1'b1;
              pay_left      <= crc_dat;
            end
          end else if (payload_req_o) begin
            mb_txd        <= reg_data;
            crc           <= crc_nxt;
            pay_left      <= pay_left - 8'd1;
            payload_req_o <= (pay_left > 8'd1);
            state         <= PAYLOAD;
          end else begin
            mb_txd <= crc[7:0];
            state  <= CRC_LO;
          end
        end

        CRC_LO: begin
          mb_txd <= crc[15:8];
          state  <= CRC_HI;
        end

        CRC_HI: begin
          mb_txd   <= 8'h00;
          mb_tx_en <= 1'b0;
          tx_done  <= 1'b1;
          crc      <= CRC_INIT;
          state    <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_rtu_tx.sv
// Self-checking bench for mb_rtu_tx: vector table, hand-written corner
// sequences and randomized frames against a byte-queue frame model.
module tb_mb_rtu_tx;

  localparam logic [7:0] DEV = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en_pulse = 1'b0;
  logic [15:0] mb_addr = 16'h0;
  logic [15:0] mb_num = 16'h0;
  logic [7:0]  mb_fun = 8'h0;
  logic [7:0]  reg_data = 8'h0;
  logic        payload_req_o;
  logic        tx_done;
  logic        mb_tx_en;
  logic [7:0]  mb_txd;

  mb_rtu_tx #(.DEV_ADDR(DEV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_en_pulse   (tx_en_pulse),
    .mb_addr       (mb_addr),
    .mb_num        (mb_num),
    .mb_fun        (mb_fun),
    .reg_data      (reg_data),
    .payload_req_o (payload_req_o),
    .tx_done       (tx_done),
    .mb_tx_en      (mb_tx_en),
    .mb_txd        (mb_txd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] pay [256];
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         exp_npay;
  int         cap_npay;

  typedef struct {
    logic [7:0]  fun;
    logic [15:0] addr;
    logic [15:0] num;
    int          len;
    int          npay;
    logic [7:0]  b1;
    logic [7:0]  b2;
  } vec_t;

  vec_t       tv [12];
  logic [7:0] k06 [8];
  logic [7:0] rf;
  logic [15:0] ra, rn;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap_q.size()) return {24'h0, cap_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic fill_random_payload();
    for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
  endtask

  // Frame model: list the bytes the protocol requires, then append CRC.
  task automatic build_exp(input logic [7:0] fun, input logic [15:0] addr, input logic [15:0] num);
    logic [15:0] c;
    logic        rd;
    rd = (fun == 8'h03) || (fun == 8'h04);
    exp_q.delete();
    exp_npay = 0;
    exp_q.push_back(DEV);
    if (rd && num >= 1 && num <= 125) begin
      exp_npay = 2 * int'(num);
      exp_q.push_back(fun);
      exp_q.push_back(exp_npay[7:0]);
      for (int i = 0; i < exp_npay; i++) exp_q.push_back(pay[i]);
    end else if (fun == 8'h06 || fun == 8'h10) begin
      exp_q.push_back(fun);
      exp_q.push_back(addr[15:8]);
      exp_q.push_back(addr[7:0]);
      exp_q.push_back(num[15:8]);
      exp_q.push_back(num[7:0]);
    end else begin
      exp_q.push_back(fun | 8'h80);
      exp_q.push_back(rd ? 8'h03 : 8'h01);
    end
    c = 16'hFFFF;
    foreach (exp_q[i]) begin
      c = c ^ {8'h00, exp_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  // Called at a negedge; returns at the negedge where tx_done is seen.
  task automatic do_frame(input string nm, input logic [7:0] fun, input logic [15:0] addr,
                          input logic [15:0] num, input int glitch);
    int first_en, last_en, n_en, first_req_c, last_req_c, first_req_idx, done_c, k;
    build_exp(fun, addr, num);
    mb_fun = fun; mb_addr = addr; mb_num = num;
    tx_en_pulse = 1'b1;
    @(negedge clk);
    tx_en_pulse = 1'b0;
    // Scramble the request inputs to prove they were latched.
    mb_fun = 8'($urandom); mb_addr = 16'($urandom); mb_num = 16'($urandom);
    cap_q.delete();
    first_en = -1; last_en = -1; n_en = 0; cap_npay = 0;
    first_req_c = -1; last_req_c = -1; first_req_idx = -1; done_c = -1; k = 0;
    for (int c = 0; c < 400; c++) begin
      tx_en_pulse = (c == glitch);
      if (mb_tx_en) begin
        cap_q.push_back(mb_txd);
        if (first_en < 0) first_en = c;
        last_en = c;
        n_en++;
      end
      if (payload_req_o) begin
        if (first_req_c < 0) begin
          first_req_c = c;
          first_req_idx = cap_q.size() - 1;
        end
        last_req_c = c;
        cap_npay++;
        reg_data = (k < 256) ? pay[k] : 8'h00;
        k++;
      end else begin
        reg_data = 8'($urandom);
      end
      if (tx_done) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
    tx_en_pulse = 1'b0;
    check({nm, " tx_done seen"}, 32'(done_c >= 0), 1);
    check({nm, " length"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check({nm, " byte"}, cap_at(i), {24'h0, exp_q[i]});
    check({nm, " first byte cycle"}, first_en, 0);
    check({nm, " tx_en contiguous"}, last_en - first_en + 1, n_en);
    check({nm, " tx_done cycle"}, done_c, exp_q.size());
    check({nm, " payload_req cycles"}, cap_npay, exp_npay);
    if (exp_npay > 0) begin
      check({nm, " payload_req starts on byte count"}, first_req_idx, 2);
      check({nm, " payload_req contiguous"}, last_req_c - first_req_c + 1, cap_npay);
    end
  endtask

  initial begin
    tv[0]  = '{8'h03, 16'h0000, 16'd10,     25,  20,  8'h03, 8'h14};
    tv[1]  = '{8'h04, 16'h0010, 16'd1,      7,   2,   8'h04, 8'h02};
    tv[2]  = '{8'h03, 16'h0000, 16'd125,    255, 250, 8'h03, 8'hFA};
    tv[3]  = '{8'h03, 16'h0000, 16'd126,    5,   0,   8'h83, 8'h03};
    tv[4]  = '{8'h03, 16'h0000, 16'd0,      5,   0,   8'h83, 8'h03};
    tv[5]  = '{8'h04, 16'h0000, 16'h0101,   5,   0,   8'h84, 8'h03};
    tv[6]  = '{8'h06, 16'h1234, 16'h5678,   8,   0,   8'h06, 8'h12};
    tv[7]  = '{8'h10, 16'hABCD, 16'h0002,   8,   0,   8'h10, 8'hAB};
    tv[8]  = '{8'h2B, 16'h0000, 16'h0001,   5,   0,   8'hAB, 8'h01};
    tv[9]  = '{8'h00, 16'h0000, 16'h0001,   5,   0,   8'h80, 8'h01};
    tv[10] = '{8'hFF, 16'h0000, 16'h0001,   5,   0,   8'hFF, 8'h01};
    tv[11] = '{8'h83, 16'h0000, 16'h0005,   5,   0,   8'h83, 8'h01};
    k06 = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};

    // Reset state (async assertion at time ~1).
    #1 rst_n = 1'b1;
    #1;
    check("reset payload_req_o", payload_req_o, 0);
    check("reset tx_done", tx_done, 0);
    check("reset mb_tx_en", mb_tx_en, 0);
    check("reset mb_txd", mb_txd, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);

    // Read of 10 registers with a fixed payload.
    for (int i = 0; i < 6; i++) pay[i] = 8'h11 + 8'(i);
    for (int i = 0; i < 14; i++) pay[6 + i] = 8'h20 + 8'(i);
    do_frame("read10", 8'h03, 16'h0000, 16'd10, -1);
    check("read10 hdr0", cap_at(0), 32'h01);
    check("read10 hdr1", cap_at(1), 32'h03);
    check("read10 hdr2", cap_at(2), 32'h14);
    check("read10 first data", cap_at(3), 32'h11);
    check("read10 last data", cap_at(22), 32'h2D);
    check("read10 total bytes", cap_q.size(), 25);
    check("read10 payload_req cycles", cap_npay, 20);
    @(negedge clk);
    check("tx_done is single cycle", tx_done, 0);

    // Known write-single frame including its CRC.
    do_frame("write06", 8'h06, 16'h0001, 16'h0003, -1);
    for (int i = 0; i < 8; i++) check("write06 known byte", cap_at(i), {24'h0, k06[i]});
    check("write06 no payload_req", cap_npay, 0);
    @(negedge clk);

    // Vector table.
    for (int t = 0; t < 12; t++) begin
      fill_random_payload();
      do_frame("vec", tv[t].fun, tv[t].addr, tv[t].num, -1);
      check("vec len", cap_q.size(), tv[t].len);
      check("vec npay", cap_npay, tv[t].npay);
      check("vec byte1", cap_at(1), {24'h0, tv[t].b1});
      check("vec byte2", cap_at(2), {24'h0, tv[t].b2});
      @(negedge clk);
    end

    // Start request repeated mid-frame is ignored.
    fill_random_payload();
    do_frame("glitch read", 8'h04, 16'h0000, 16'd3, 4);
    @(negedge clk);
    check("glitch no extra frame", mb_tx_en, 0);
    do_frame("glitch write", 8'h10, 16'h0F0F, 16'h0007, 2);
    @(negedge clk);
    check("glitch write no extra frame", mb_tx_en, 0);

    // Back-to-back: second start lands on the tx_done cycle.
    fill_random_payload();
    do_frame("b2b first", 8'h03, 16'h0000, 16'd2, -1);
    do_frame("b2b second", 8'h10, 16'h0102, 16'h0304, -1);
    do_frame("b2b third", 8'h55, 16'h0000, 16'h0000, -1);
    @(negedge clk);

    // Reset asserted during payload.
    fill_random_payload();
    mb_fun = 8'h03; mb_addr = 16'h0; mb_num = 16'd10;
    tx_en_pulse = 1'b1;
    @(negedge clk);
    tx_en_pulse = 1'b0;
    begin
      int k = 0;
      for (int c = 0; c < 6; c++) begin
        if (payload_req_o) begin reg_data = pay[k]; k++; end
        @(negedge clk);
      end
    end
    check("pre-reset in payload", payload_req_o, 1);
    #2 rst_n = 1'b1;
    #1;
    check("midreset payload_req_o", payload_req_o, 0);
    check("midreset tx_done", tx_done, 0);
    check("midreset mb_tx_en", mb_tx_en, 0);
    check("midreset mb_txd", mb_txd, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    begin
      int n = 0;
      for (int c = 0; c < 30; c++) begin
        if (mb_tx_en || payload_req_o || tx_done) n++;
        @(negedge clk);
      end
      check("no frame resumes after reset", n, 0);
    end
    do_frame("post-reset write06", 8'h06, 16'h0001, 16'h0003, -1);
    for (int i = 0; i < 8; i++) check("post-reset known byte", cap_at(i), {24'h0, k06[i]});
    @(negedge clk);

    // Randomized frames against the model.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 5))
        0: rf = 8'h03;
        1: rf = 8'h04;
        2: rf = 8'h06;
        3: rf = 8'h10;
        4: rf = 8'($urandom);
        default: rf = 8'h03;
      endcase
      case ($urandom_range(0, 3))
        0: rn = 16'($urandom_range(1, 8));
        1: rn = 16'($urandom_range(120, 130));
        2: rn = 16'($urandom);
        default: rn = 16'($urandom_range(0, 3));
      endcase
      ra = 16'($urandom);
      fill_random_payload();
      do_frame("rand", rf, ra, rn, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
